// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport is the datapath/memory side.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-line instruction cache with a blocking refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     data;
  } line_t;

  state_t          state, state_n;
  logic [31:0]     miss_addr;
  logic [SETS-1:0] valid;
  line_t           lines [SETS];

  logic [IDX-1:0]  req_idx, fill_idx;
  logic [TAGW-1:0] req_tag;
  logic            hit, miss_start, fill;
  logic            ihit_c, iren_c;
  logic [31:0]     load_c, iaddr_c;

  assign req_idx  = bus.imemaddr[IDX+1:2];
  assign req_tag  = bus.imemaddr[31:IDX+2];
  assign fill_idx = miss_addr[IDX+1:2];

  always_comb begin
    state_n    = state;
    hit        = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    ihit_c     = 1'b0;
    load_c     = '0;
    iren_c     = 1'b0;
    iaddr_c    = '0;
    case (state)
      IDLE: begin
        hit    = bus.imemREN & valid[req_idx] & (lines[req_idx].tag == req_tag) & ~bus.flush;
        ihit_c = hit;
        load_c = hit ? lines[req_idx].data : '0;
        if (bus.imemREN & ~hit & ~bus.flush) begin
          miss_start = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        // The refill always runs to completion; imemREN dropping does not abort it.
        iren_c  = 1'b1;
        iaddr_c = miss_addr;
        if (!bus.iwait) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ihit     = ihit_c;
  assign bus.imemload = load_c;
  assign bus.iREN     = iren_c;
  assign bus.iaddr    = iaddr_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      state <= state_n;
      if (miss_start) miss_addr <= {bus.imemaddr[31:2], 2'b00};
      // A flush wins over a refill landing in the same cycle: data is written, line stays invalid.
      if (bus.flush)  valid <= '0;
      else if (fill)  valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && fill) lines[fill_idx] <= '{tag: miss_addr[31:IDX+2], data: bus.iload};
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit_c && hit_count != '1)      hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against an array-based cache/memory model.
module tb_icache;
  localparam int SETS = 16;
  localparam int IDX  = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_if u ();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(.SETS(SETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          fills;
  } exp_t;

  exp_t        sbq [$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mvalid [SETS];
  logic [31:0] mtag [SETS];
  int          m_hits, m_misses;
  int          force_wait = -1;
  logic [31:0] cur_addr = '0;
  int          last_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h40) return 32'h2008_0005;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ (w >> 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
  endtask

  // Memory controller: random wait states, data from mem_word().
  initial begin
    bit in_tx;
    int wl;
    in_tx = 1'b0;
    wl = 0;
    u.iwait = 1'b1;
    u.iload = '0;
    forever begin
      @(posedge CLK); #1;
      if (u.iREN) begin
        if (!in_tx) begin
          in_tx = 1'b1;
          wl = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          chk("iaddr", u.iaddr, {cur_addr[31:2], 2'b00});
        end
        if (wl > 0) begin
          u.iwait = 1'b1;
          u.iload = $urandom;
          wl--;
        end else begin
          u.iwait = 1'b0;
          u.iload = mem_word(u.iaddr);
          in_tx = 1'b0;
        end
      end else begin
        in_tx = 1'b0;
        u.iwait = 1'($urandom_range(0, 1));
        u.iload = $urandom;
      end
    end
  end

  // Monitor: pops one expectation per ihit.
  initial begin
    int   cyc, fills;
    exp_t e;
    cyc = 0;
    fills = 0;
    forever begin
      @(negedge CLK);
      if (RST || !u.imemREN) begin
        cyc = 0;
        fills = 0;
      end else begin
        cyc++;
        if (u.iREN && !u.iwait) fills++;
        if (u.ihit) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_hit: got ihit=1 expected no pending request at %0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("imemload", u.imemload, e.data);
            chk("refills", fills, e.fills);
            if (e.fills == 0) chk("hit_latency", cyc, 1);
          end
          cyc = 0;
          fills = 0;
        end
      end
      if (!u.ihit) chk("imemload_zero", u.imemload, 32'h0);
    end
  end

  task automatic fetch(input logic [31:0] a, input bit fl);
    exp_t e;
    int   idx, n;
    bit   hit, flushed, done;
    idx = int'((a >> 2) % SETS);
    hit = mvalid[idx] && (mtag[idx] == (a >> (IDX + 2)));
    e.data  = mem_word(a);
    e.fills = hit ? 0 : (fl ? 2 : 1);
    if (!hit && fl) model_clear();
    mvalid[idx] = 1'b1;
    mtag[idx]   = a >> (IDX + 2);
    m_hits++;
    m_misses += e.fills;
    sbq.push_back(e);
    cur_addr   = a;
    u.imemREN  = 1'b1;
    u.imemaddr = {a[31:2], 2'($urandom)};
    n = 0;
    flushed = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (u.ihit) done = 1'b1;
      @(posedge CLK); #2;
      u.flush = 1'b0;
      if (!done) begin
        n++;
        if (n > 60) begin
          vectors++;
          miscompares++;
          $display("FAIL fetch_timeout: got no ihit expected ihit for addr %h", a);
          sbq.delete();
          done = 1'b1;
        end else if (fl && !flushed && u.iREN && !u.iwait) begin
          u.flush = 1'b1;
          flushed = 1'b1;
        end
      end
    end
    last_lat = n;
  endtask

  task automatic idle(input int n);
    u.imemREN = 1'b0;
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic do_flush();
    u.imemREN = 1'b0;
    u.flush = 1'b1;
    model_clear();
    @(posedge CLK); #2;
    u.flush = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    u.imemREN = 1'b0;
    u.flush = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    RST = 1'b1;
    u.imemREN = 1'b0;
    u.flush = 1'b0;
    u.imemaddr = '0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;

    chk("rst_ihit", u.ihit, 0);
    chk("rst_imemload", u.imemload, 0);
    chk("rst_iREN", u.iREN, 0);
    chk("rst_iaddr", u.iaddr, 0);
    chk_stats();

    // Cold miss with three wait states, then three hits.
    force_wait = 3;
    fetch(32'h40, 1'b0);
    force_wait = -1;
    chk("cold_latency", last_lat, 5);
    fetch(32'h40, 1'b0);
    fetch(32'h40, 1'b0);
    fetch(32'h40, 1'b0);
    idle(1);
    chk_stats();

    // Hit stream.
    fetch(32'h00, 1'b0); fetch(32'h04, 1'b0); fetch(32'h08, 1'b0);
    idle(1);
    fetch(32'h00, 1'b0); fetch(32'h04, 1'b0); fetch(32'h08, 1'b0);
    idle(1);

    // Conflict on index 1.
    fetch(32'h04, 1'b0); fetch(32'h44, 1'b0); fetch(32'h04, 1'b0);
    idle(1);

    // Flush between requests, and flush landing on a refill.
    fetch(32'h10, 1'b0);
    idle(1);
    do_flush();
    fetch(32'h10, 1'b0);
    fetch(32'h20, 1'b1);
    fetch(32'h20, 1'b0);
    idle(1);

    // Reset while a refill is waiting.
    fetch(32'h30, 1'b0);
    force_wait = 5;
    cur_addr   = 32'h200;
    u.imemREN  = 1'b1;
    u.imemaddr = 32'h200;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("fetch_iREN", u.iREN, 1);
    do_reset();
    force_wait = -1;
    chk("post_rst_iREN", u.iREN, 0);
    chk("post_rst_ihit", u.ihit, 0);
    fetch(32'h30, 1'b0);
    fetch(32'h30, 1'b0);
    idle(1);
    chk_stats();

    // Random traffic with aliasing tags.
    repeat (300) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) do_flush();
      else if (r == 1) idle(int'($urandom_range(1, 3)));
      else begin
        a = {11'd0, 1'($urandom_range(0, 1)), 12'd0, 6'($urandom_range(0, 63)), 2'b00};
        fetch(a, $urandom_range(0, 9) == 0);
      end
    end
    idle(2);
    chk_stats();
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
